// File: rtl/arb_pkg.sv
// Shared definitions for the five-way round-robin arbiter.
//   N_REQ / IDX_W : requester count and index width
//   state_t       : controller state encoding
//   pick_t        : winner index plus found flag from rr_pick
//   next_idx      : circular increment of a requester index (4 wraps to 0)
//   rr_pick       : first set request bit scanning circularly from a start index
//   onehot        : index to one-hot grant vector
package arb_pkg;

  localparam int N_REQ = 5;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Explicit wrap so index values 5..7 can never be produced.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i >= IDX_W'(N_REQ - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [IDX_W-1:0] start);
    pick_t            p;
    logic [IDX_W-1:0] cur;
    p   = '0;
    cur = start;
    for (int j = 0; j < N_REQ; j++) begin
      if (!p.found && req[cur]) begin
        p.found = 1'b1;
        p.idx   = cur;
      end
      cur = next_idx(cur);
    end
    return p;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return N_REQ'(1) << i;
  endfunction

endpackage

// File: rtl/five_bit_or.sv
// Any-request detector: reduction OR of a 5-bit vector.
//   inp : 5-bit input vector
//   out : high when any bit of inp is high (purely combinational)
module five_bit_or (
  input  logic [4:0] inp,
  output logic       out
);

  assign out = |inp;

endmodule

// File: rtl/rr_arbiter_5.sv
// Round-robin arbiter sharing one resource among five requesters.
// The owner keeps the grant while it requests, for at most MAX_HOLD
// consecutive cycles; then it is pre-empted and arbitration restarts
// just after it.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   req       : request vector, bit i held while requester i needs the resource
//   gnt       : registered one-hot grant (or zero)
//   gnt_id    : registered index of the owner, meaningful when gnt_valid=1
//   gnt_valid : registered, high exactly when gnt is non-zero
//   any_req   : combinational OR of req
//   timeout   : registered one-cycle pulse when the owner is pre-empted
module rr_arbiter_5
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_id,
  output logic             gnt_valid,
  output logic             any_req,
  output logic             timeout
);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic [CNT_W-1:0] hold_reg, hold_next;
  logic [N_REQ-1:0] gnt_reg, gnt_next;
  logic [IDX_W-1:0] gnt_id_reg, gnt_id_next;
  logic             gnt_valid_reg, gnt_valid_next;
  logic             timeout_reg, timeout_next;

  logic [IDX_W-1:0] owner_succ;
  pick_t            idle_pick, release_pick, preempt_pick;

  five_bit_or u_any_req (
    .inp (req),
    .out (any_req)
  );

  assign owner_succ   = next_idx(gnt_id_reg);
  assign idle_pick    = rr_pick(req, ptr_reg);
  // On release the departing owner is excluded so the hand-over is gapless.
  assign release_pick = rr_pick(req & ~onehot(gnt_id_reg), owner_succ);
  // On pre-emption the owner stays eligible; it wins only if it is alone.
  assign preempt_pick = rr_pick(req, owner_succ);

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    hold_next      = hold_reg;
    gnt_next       = gnt_reg;
    gnt_id_next    = gnt_id_reg;
    gnt_valid_next = gnt_valid_reg;
    timeout_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next     = GRANT;
          gnt_next       = onehot(idle_pick.idx);
          gnt_id_next    = idle_pick.idx;
          gnt_valid_next = 1'b1;
          hold_next      = '0;
        end
      end

      GRANT: begin
        hold_next = hold_reg + CNT_W'(1);
        // Release is tested first so a drop on the last hold cycle
        // never produces a timeout pulse.
        if (!req[gnt_id_reg]) begin
          ptr_next  = owner_succ;
          hold_next = '0;
          if (release_pick.found) begin
            gnt_next    = onehot(release_pick.idx);
            gnt_id_next = release_pick.idx;
          end else begin
            state_next     = IDLE;
            gnt_next       = '0;
            gnt_valid_next = 1'b0;
          end
        end else if (hold_reg == CNT_W'(MAX_HOLD - 1)) begin
          timeout_next = 1'b1;
          ptr_next     = owner_succ;
          hold_next    = '0;
          gnt_next     = onehot(preempt_pick.idx);
          gnt_id_next  = preempt_pick.idx;
        end
      end

      default: begin
        state_next     = IDLE;
        gnt_next       = '0;
        gnt_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      hold_reg      <= '0;
      gnt_reg       <= '0;
      gnt_id_reg    <= '0;
      gnt_valid_reg <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      hold_reg      <= hold_next;
      gnt_reg       <= gnt_next;
      gnt_id_reg    <= gnt_id_next;
      gnt_valid_reg <= gnt_valid_next;
      timeout_reg   <= timeout_next;
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_id    = gnt_id_reg;
  assign gnt_valid = gnt_valid_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter_5.sv
// Self-checking bench for rr_arbiter_5: a cycle model pushes the expected
// registered outputs when each request vector is driven, and they are
// popped and compared after the following clock edge.
module tb_rr_arbiter_5;

  localparam int MAX_HOLD = 8;
  localparam int CNT_W    = 4;
  localparam int BOUND    = 4 * MAX_HOLD + 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] req   = 5'b00000;
  logic [4:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       any_req;
  logic       timeout;

  rr_arbiter_5 #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .any_req   (any_req),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [4:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic       to;
  } exp_t;

  exp_t exp_q[$];

  int m_valid, m_owner, m_ptr, m_hold;
  int wait_cnt[5];

  function automatic int win(input logic [4:0] r, input int s);
    for (int j = 0; j < 5; j++) begin
      if (r[(s + j) % 5]) return (s + j) % 5;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_owner = 0;
    m_ptr   = 0;
    m_hold  = 0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) wait_cnt[i] = 0;
  endtask

  task automatic model_push(input logic [4:0] r);
    exp_t       e;
    logic [4:0] others;
    int         to;
    to = 0;
    if (m_valid == 0) begin
      if (r != 5'b00000) begin
        m_owner = win(r, m_ptr);
        m_valid = 1;
        m_hold  = 0;
      end
    end else if (!r[m_owner]) begin
      m_ptr  = (m_owner + 1) % 5;
      others = r & ~(5'b00001 << m_owner);
      m_hold = 0;
      if (others != 5'b00000) m_owner = win(others, m_ptr);
      else m_valid = 0;
    end else if (m_hold == MAX_HOLD - 1) begin
      to      = 1;
      m_ptr   = (m_owner + 1) % 5;
      m_owner = win(r, m_ptr);
      m_hold  = 0;
    end else begin
      m_hold++;
    end
    e.valid = (m_valid != 0);
    e.gnt   = (m_valid != 0) ? (5'b00001 << m_owner) : 5'b00000;
    e.id    = 3'(m_owner);
    e.to    = (to != 0);
    exp_q.push_back(e);
  endtask

  // One clock of stimulus: drive at negedge, check after the next posedge.
  task automatic step(input logic [4:0] r);
    exp_t e;
    int   ones;
    logic starved;
    @(negedge clk);
    req = r;
    #1;
    vectors++;
    if (any_req !== (|r)) begin
      miscompares++;
      $display("FAIL any_req req=%b got=%b expected=%b", r, any_req, |r);
    end
    model_push(r);
    @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty got=none expected=entry");
    end else begin
      e = exp_q.pop_front();
      if (gnt !== e.gnt) begin
        miscompares++;
        $display("FAIL gnt req=%b got=%b expected=%b", r, gnt, e.gnt);
      end
      vectors++;
      if (gnt_valid !== e.valid) begin
        miscompares++;
        $display("FAIL gnt_valid req=%b got=%b expected=%b", r, gnt_valid, e.valid);
      end
      vectors++;
      if (timeout !== e.to) begin
        miscompares++;
        $display("FAIL timeout req=%b got=%b expected=%b", r, timeout, e.to);
      end
      if (e.valid) begin
        vectors++;
        if (gnt_id !== e.id) begin
          miscompares++;
          $display("FAIL gnt_id req=%b got=%0d expected=%0d", r, gnt_id, e.id);
        end
      end
    end
    // Structural invariants on the registered grant.
    ones = $countones(gnt);
    vectors++;
    if (ones > 1 || gnt_valid !== (|gnt) ||
        (gnt_valid && gnt !== (5'b00001 << gnt_id))) begin
      miscompares++;
      $display("FAIL invariant gnt=%b gnt_id=%0d gnt_valid=%b", gnt, gnt_id, gnt_valid);
    end
    starved = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (r[i] && !gnt[i]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > BOUND) starved = 1'b1;
    end
    vectors++;
    if (starved) begin
      miscompares++;
      $display("FAIL starvation req=%b got=waiting>%0d expected=granted", r, BOUND);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req   = 5'b00000;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if (gnt !== 5'b00000 || gnt_valid !== 1'b0 || timeout !== 1'b0 || gnt_id !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_state got=%b/%b/%b/%0d expected=00000/0/0/0",
               gnt, gnt_valid, timeout, gnt_id);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 10; c++) begin
      step(5'b00000);
      vectors++;
      if (gnt !== 5'b00000 || gnt_valid !== 1'b0 || any_req !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle cycle=%0d got=%b/%b/%b expected=00000/0/0",
                 c, gnt, gnt_valid, any_req);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    step(5'b00100);
    vectors++;
    if (gnt !== 5'b00100 || gnt_id !== 3'd2 || gnt_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL single_grant got=%b/%0d/%b expected=00100/2/1", gnt, gnt_id, gnt_valid);
    end
    step(5'b00100);
    step(5'b00100);
    step(5'b00000);
    vectors++;
    if (gnt !== 5'b00000 || gnt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_release got=%b/%b expected=00000/0", gnt, gnt_valid);
    end
  endtask

  task automatic test_rotation();
    logic [4:0] r;
    logic [4:0] want;
    do_reset();
    r = 5'b11111;
    step(r);
    vectors++;
    if (gnt !== 5'b00001) begin
      miscompares++;
      $display("FAIL rotation_first got=%b expected=00001", gnt);
    end
    for (int k = 0; k < 5; k++) begin
      step(r);
      r[k] = 1'b0;
      if (k == 4) r[0] = 1'b1;
      step(r);
      want = (k == 4) ? 5'b00001 : (5'b00001 << (k + 1));
      vectors++;
      if (gnt !== want) begin
        miscompares++;
        $display("FAIL rotation_handover owner=%0d got=%b expected=%b", k, gnt, want);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      step(5'b00011);
      if (i == 1 || i == 8 || i == 9 || i == 10 || i == 16 || i == 17) begin
        vectors++;
        if (i == 1 || i == 8) begin
          if (gnt !== 5'b00001 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_first cycle=%0d got=%b/%b expected=00001/0", i, gnt, timeout);
          end
        end else if (i == 9) begin
          if (gnt !== 5'b00010 || timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL preempt_0 cycle=%0d got=%b/%b expected=00010/1", i, gnt, timeout);
          end
        end else if (i == 10 || i == 16) begin
          if (gnt !== 5'b00010 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_second cycle=%0d got=%b/%b expected=00010/0", i, gnt, timeout);
          end
        end else begin
          if (gnt !== 5'b00001 || timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL preempt_1 cycle=%0d got=%b/%b expected=00001/1", i, gnt, timeout);
          end
        end
      end
    end
    // Lone requester: re-granted for a fresh window with a pulse.
    do_reset();
    for (int i = 1; i <= 9; i++) step(5'b01000);
    vectors++;
    if (gnt !== 5'b01000 || timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL lone_regrant got=%b/%b expected=01000/1", gnt, timeout);
    end
  endtask

  task automatic test_coincide();
    do_reset();
    for (int i = 1; i <= 8; i++) step(5'b00001);
    step(5'b00010);
    vectors++;
    if (gnt !== 5'b00010 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL release_beats_preempt got=%b/%b expected=00010/0", gnt, timeout);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(5'b01000);
    step(5'b01000);
    vectors++;
    if (gnt !== 5'b01000) begin
      miscompares++;
      $display("FAIL async_setup got=%b expected=01000", gnt);
    end
    #2;
    req   = 5'b00000;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (gnt !== 5'b00000 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset got=%b/%b/%b expected=00000/0/0", gnt, gnt_valid, timeout);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(5'b01001);
    vectors++;
    if (gnt !== 5'b00001 || gnt_id !== 3'd0) begin
      miscompares++;
      $display("FAIL ptr_after_reset got=%b/%0d expected=00001/0", gnt, gnt_id);
    end
  endtask

  task automatic test_random();
    logic [4:0] r;
    do_reset();
    r = 5'b00000;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) r = 5'($urandom_range(0, 31));
      step(r);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_coincide();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rr_arbiter_5.md
Name: rr_arbiter_5

Overview:
- Round-robin arbiter that shares one resource among five requesters.
- Uses five_bit_or as its any-request detector.
- Issues a one-hot grant, holds it while the owner keeps requesting, and pre-empts after a bounded hold window.
- Sits between the five request sources and the shared datapath. It is the sequencing controller for the 5-bit request vector.

Parameters:
- MAX_HOLD, default 8: maximum consecutive cycles one requester may hold the grant. Legal range 1..15.
- CNT_W, default 4: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  5  request vector; bit i is held high while requester i wants or uses the resource.
- gnt  output  5  one-hot grant, or all zero.
- gnt_id  output  3  index of the granted requester (0..4); valid only when gnt_valid=1.
- gnt_valid  output  1  high exactly when gnt is non-zero.
- any_req  output  1  combinational OR of req, produced by the five_bit_or instance.
- timeout  output  1  one-cycle pulse on pre-emption of the current owner.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately, including mid-grant):
  - gnt=0, gnt_id=0, gnt_valid=0, timeout=0.
  - Priority pointer ptr=0, hold_cnt=0, state=IDLE.
  - any_req stays purely combinational.
- Winner selection (combinational, start index s):
  - First i in circular order s, s+1, …, 4, 0, …, s-1 with req[i]=1.
  - Index arithmetic is mod 5. Pointer wrap 4→0 is mandatory; values 5..7 never occur.
- IDLE:
  - If any_req=1, at the next edge: gnt=onehot(winner(ptr)), gnt_id=winner, hold_cnt=0, go to GRANT.
  - Latency from req rising to gnt is one cycle.
  - If any_req=0, stay in IDLE with outputs 0.
- GRANT, owner k = gnt_id. At each edge, hold_cnt increments. Decisions are made on the sampled req:
  - Release (req[k]=0):
    - ptr←k+1 mod 5.
    - If any other req bit is set, grant winner(k+1) at this same edge, with no dead cycle, and reset hold_cnt=0.
    - Otherwise drop gnt to 0 and go to IDLE.
  - Pre-empt (req[k]=1 and hold_cnt==MAX_HOLD-1):
    - timeout=1 for exactly one cycle, ptr←k+1 mod 5, hold_cnt=0.
    - Re-arbitrate with start k+1 over all req bits.
    - If k is the only requester it is re-granted for a fresh window, and the timeout pulse is still issued.
  - Otherwise keep gnt unchanged.
- Simultaneous events: release takes precedence over pre-empt. No timeout pulse is issued when req[k] drops on the final hold cycle.
- New requests during GRANT never disturb the current owner before release or pre-emption.
- Invariants, checked in verification:
  - gnt has popcount ≤ 1.
  - gnt_valid == |gnt.
  - gnt_id matches the set bit of gnt.
  - A requester with req high continuously is granted within 4*MAX_HOLD+4 cycles (starvation bound).
- Outputs gnt, gnt_id, gnt_valid and timeout are all registered.

Decomposition:
- Package arb_pkg holds:
  - N_REQ=5 and IDX_W=3.
  - State encoding IDLE=1'b0, GRANT=1'b1.
  - A function rr_pick(req, start) returning the winner index and a found flag.
  - A function next_idx(i) that computes i+1 mod 5.
- One sub-module instance: five_bit_or (inp=req, out=any_req). It is reused unchanged.

Test Plan:
- Reset release with req=00000 → gnt=00000, gnt_valid=0, any_req=0 for 10 cycles.
- req=00100 driven at cycle 0 → next edge gnt=00100, gnt_id=2, gnt_valid=1. Drop req at cycle 3 → gnt=00000 at cycle 4.
- req=11111 from reset, each owner dropping its bit after 2 cycles:
  - Grants run 00001 → 00010 → 00100 → 01000 → 10000 with no gaps.
  - After 10000 releases, the wrap delivers the next grant to bit 0 if it is re-asserted.
- MAX_HOLD=8, req=00011 held constantly:
  - gnt=00001 for 8 cycles, then timeout pulse, then gnt=00010 for 8 cycles, then timeout, then back to 00001.
- Release and pre-empt coincide: req[0] drops on hold cycle 8 with req=00010 → timeout=0, gnt=00010 next edge.
- rst_n pulled low asynchronously mid-grant with gnt=01000 → gnt=0 and gnt_valid=0 immediately, without waiting for a clock edge. After release, req=01001 yields gnt=00001 (ptr reset to 0).
